// File: rtl/mux_group_pkg.sv
// Shared definitions for the registered multiplexer group:
// state encodings, mode values and the select-width helper.
package mux_group_pkg;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_HOLD = 2'd1;
   localparam logic [1:0] ST_SCAN = 2'd2;

   localparam logic MODE_DIRECT = 1'b0;
   localparam logic MODE_SCAN   = 1'b1;

   typedef enum logic [1:0] {
      S_IDLE = ST_IDLE,
      S_HOLD = ST_HOLD,
      S_SCAN = ST_SCAN
   } state_t;

   // Bits needed to index n channels (minimum 1).
   function automatic int sel_width(input int n);
      int w;
      w = 1;
      for (int i = 1; i < 31; i++) begin
         if ((1 << i) < n) begin
            w = i + 1;
         end
      end
      return w;
   endfunction

endpackage

// File: rtl/mux_ch_select.sv
// Combinational NCH:1 selector, DW bits wide.
// Ports: data (flattened channels, channel c at [c*DW +: DW]),
//        sel (channel index), y (selected channel).
module mux_ch_select #(
   parameter int DW  = 4,
   parameter int NCH = 4,
   parameter int SW  = 2
) (
   input  logic [NCH*DW-1:0] data,
   input  logic [SW-1:0]     sel,
   output logic [DW-1:0]     y
);

   always_comb begin
      y = '0;
      for (int c = 0; c < NCH; c++) begin
         if (sel == c[SW-1:0]) begin
            y = data[c*DW +: DW];
         end
      end
   end

endmodule

// File: rtl/mux_group_seq.sv
// Registered N-channel mux group: direct single-channel select or
// snapshot-and-stream scan of all channels, valid/ready on both sides.
// Ports: iClk, iRst_n (async, active low); request side iData, iSel,
//        iMode, iValid, oReady; beat side oD, oCh, oLast, oValid, iReady.
module mux_group_seq
   import mux_group_pkg::*;
#(
   parameter int DW  = 4,
   parameter int NCH = 4,
   localparam int SW = sel_width(NCH)
) (
   input  logic              iClk,
   input  logic              iRst_n,
   input  logic [NCH*DW-1:0] iData,
   input  logic [SW-1:0]     iSel,
   input  logic              iMode,
   input  logic              iValid,
   output logic              oReady,
   output logic [DW-1:0]     oD,
   output logic [SW-1:0]     oCh,
   output logic              oLast,
   output logic              oValid,
   input  logic              iReady
);

   localparam logic [SW-1:0] CNT_MAX = SW'(NCH - 1);

   state_t            state;
   state_t            state_nxt;
   logic [SW-1:0]     cnt;
   logic [SW-1:0]     cnt_nxt;
   logic [NCH*DW-1:0] snap;
   logic [NCH*DW-1:0] snap_nxt;
   logic [DW-1:0]     d_q;
   logic [DW-1:0]     d_nxt;
   logic [SW-1:0]     ch_q;
   logic [SW-1:0]     ch_nxt;
   logic              last_q;
   logic              last_nxt;
   logic              valid_q;
   logic              valid_nxt;

   logic              ready;
   logic              accept;
   logic [SW-1:0]     cnt_inc;
   logic [SW-1:0]     ch_inc;
   logic [DW-1:0]     live_d;
   logic [DW-1:0]     snap_d;

   // Ready depends only on state and downstream ready, so a
   // request source can never form a loop through it.
   assign ready  = iRst_n &&
                   ((state == S_IDLE) ||
                    ((state == S_HOLD) && iReady));
   assign accept = iValid && ready;

   // NCH is a power of two, so plain SW-bit wrap is mod NCH.
   assign cnt_inc = cnt + 1'b1;
   assign ch_inc  = ch_q + 1'b1;

   mux_ch_select #(
      .DW  (DW),
      .NCH (NCH),
      .SW  (SW)
   ) u_live_sel (
      .data (iData),
      .sel  (iSel),
      .y    (live_d)
   );

   mux_ch_select #(
      .DW  (DW),
      .NCH (NCH),
      .SW  (SW)
   ) u_snap_sel (
      .data (snap),
      .sel  (ch_inc),
      .y    (snap_d)
   );

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      snap_nxt  = snap;
      d_nxt     = d_q;
      ch_nxt    = ch_q;
      last_nxt  = last_q;
      valid_nxt = valid_q;

      unique case (state)
         S_IDLE, S_HOLD: begin
            if (accept) begin
               d_nxt     = live_d;
               ch_nxt    = iSel;
               valid_nxt = 1'b1;
               if (iMode == MODE_SCAN) begin
                  // First beat equals snapshot[iSel]; take it
                  // from the live path since the snapshot is
                  // only being written on this edge.
                  snap_nxt  = iData;
                  cnt_nxt   = '0;
                  last_nxt  = 1'b0;
                  state_nxt = S_SCAN;
               end else begin
                  last_nxt  = 1'b1;
                  state_nxt = S_HOLD;
               end
            end else if ((state == S_HOLD) && iReady) begin
               valid_nxt = 1'b0;
               state_nxt = S_IDLE;
            end
         end
         S_SCAN: begin
            if (iReady) begin
               cnt_nxt = cnt_inc;
               ch_nxt  = ch_inc;
               d_nxt   = snap_d;
               if (cnt_inc == CNT_MAX) begin
                  last_nxt  = 1'b1;
                  state_nxt = S_HOLD;
               end
            end
         end
         default: begin
            valid_nxt = 1'b0;
            state_nxt = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge iClk or negedge iRst_n) begin
      if (!iRst_n) begin
         state   <= S_IDLE;
         cnt     <= '0;
         snap    <= '0;
         d_q     <= '0;
         ch_q    <= '0;
         last_q  <= 1'b0;
         valid_q <= 1'b0;
      end else begin
         state   <= state_nxt;
         cnt     <= cnt_nxt;
         snap    <= snap_nxt;
         d_q     <= d_nxt;
         ch_q    <= ch_nxt;
         last_q  <= last_nxt;
         valid_q <= valid_nxt;
      end
   end

   assign oReady = ready;
   assign oD     = d_q;
   assign oCh    = ch_q;
   assign oLast  = last_q;
   assign oValid = valid_q;

endmodule

// File: tb/tb_mux_group_seq.sv
// Self-checking bench for mux_group_seq: queue-based beat model,
// directed scenarios with literal expectations, then random traffic.
module tb_mux_group_seq;

   localparam int DW  = 4;
   localparam int NCH = 4;
   localparam int SW  = 2;

   typedef struct {
      logic [DW-1:0] d;
      logic [SW-1:0] ch;
      logic          last;
   } beat_t;

   logic              iClk;
   logic              iRst_n;
   logic [NCH*DW-1:0] iData;
   logic [SW-1:0]     iSel;
   logic              iMode;
   logic              iValid;
   logic              oReady;
   logic [DW-1:0]     oD;
   logic [SW-1:0]     oCh;
   logic              oLast;
   logic              oValid;
   logic              iReady;

   int    total;
   int    passed;
   bit    run;
   beat_t q[$];

   mux_group_seq #(
      .DW  (DW),
      .NCH (NCH)
   ) dut (
      .iClk   (iClk),
      .iRst_n (iRst_n),
      .iData  (iData),
      .iSel   (iSel),
      .iMode  (iMode),
      .iValid (iValid),
      .oReady (oReady),
      .oD     (oD),
      .oCh    (oCh),
      .oLast  (oLast),
      .oValid (oValid),
      .iReady (iReady)
   );

   initial iClk = 1'b0;
   always #5 iClk = ~iClk;

   task automatic check(input string nm,
                        input logic [31:0] act,
                        input logic [31:0] exp);
      total++;
      if (act === exp) begin
         passed++;
      end else begin
         $display("FAIL %s: got %0h expected %0h t=%0t",
                  nm, act, exp, $time);
      end
   endtask

   // Reference: every accepted request becomes a list of beats.
   // One beat outstanding = final beat; more = mid-scan.
   always @(posedge iClk) begin
      if (!iRst_n) begin
         q.delete();
      end else begin
         bit acc;
         bit cons;
         acc  = iValid &&
                (q.size() == 0 || (q.size() == 1 && iReady));
         cons = (q.size() > 0) && iReady;
         if (cons) void'(q.pop_front());
         if (acc) begin
            int n;
            n = iMode ? NCH : 1;
            for (int i = 0; i < n; i++) begin
               beat_t b;
               int c;
               c      = (int'(iSel) + i) % NCH;
               b.ch   = SW'(c);
               b.d    = iData[c*DW +: DW];
               b.last = (i == n - 1);
               q.push_back(b);
            end
         end
      end
   end

   always @(negedge iClk) begin
      if (run) begin
         if (!iRst_n) begin
            check("rst_valid", 32'(oValid), 0);
            check("rst_ready", 32'(oReady), 0);
            check("rst_d", 32'(oD), 0);
            check("rst_ch", 32'(oCh), 0);
            check("rst_last", 32'(oLast), 0);
         end else begin
            logic exp_rdy;
            exp_rdy = (q.size() == 0) ||
                      (q.size() == 1 && iReady);
            check("ready", 32'(oReady), 32'(exp_rdy));
            check("valid", 32'(oValid), 32'(q.size() != 0));
            if (q.size() != 0) begin
               check("d", 32'(oD), 32'(q[0].d));
               check("ch", 32'(oCh), 32'(q[0].ch));
               check("last", 32'(oLast), 32'(q[0].last));
            end
         end
      end
   end

   task automatic tick();
      @(posedge iClk);
      #1;
   endtask

   task automatic lit(input string nm,
                      input logic [DW-1:0] d,
                      input logic [SW-1:0] ch,
                      input logic last);
      @(negedge iClk);
      check({nm, "_v"}, 32'(oValid), 1);
      check({nm, "_d"}, 32'(oD), 32'(d));
      check({nm, "_ch"}, 32'(oCh), 32'(ch));
      check({nm, "_last"}, 32'(oLast), 32'(last));
   endtask

   localparam logic [NCH*DW-1:0] PAT = 16'hDCBA;

   initial begin
      total  = 0;
      passed = 0;
      run    = 1'b0;
      iRst_n = 1'b0;
      iData  = PAT;
      iSel   = '0;
      iMode  = 1'b0;
      iValid = 1'b0;
      iReady = 1'b1;
      repeat (2) @(posedge iClk);
      run = 1'b1;
      @(negedge iClk);
      check("init_valid", 32'(oValid), 0);
      check("init_ready", 32'(oReady), 0);
      tick();
      iRst_n = 1'b1;
      @(negedge iClk);
      check("rel_ready", 32'(oReady), 1);

      // direct, iSel=2
      tick();
      iMode = 1'b0; iSel = 2'd2; iValid = 1'b1;
      tick();
      iValid = 1'b0;
      lit("dir", 4'hC, 2'd2, 1'b1);
      tick();
      @(negedge iClk);
      check("dir_done", 32'(oValid), 0);

      // direct back-to-back 0,1,3
      tick();
      iSel = 2'd0; iValid = 1'b1;
      tick();
      iSel = 2'd1;
      lit("b2b0", 4'hA, 2'd0, 1'b1);
      tick();
      iSel = 2'd3;
      lit("b2b1", 4'hB, 2'd1, 1'b1);
      tick();
      iValid = 1'b0;
      lit("b2b2", 4'hD, 2'd3, 1'b1);
      tick();

      // scan from channel 3, wrapping
      iMode = 1'b1; iSel = 2'd3; iValid = 1'b1;
      tick();
      iValid = 1'b0;
      lit("scw0", 4'hD, 2'd3, 1'b0);
      check("scw0_rdy", 32'(oReady), 0);
      tick();
      lit("scw1", 4'hA, 2'd0, 1'b0);
      tick();
      lit("scw2", 4'hB, 2'd1, 1'b0);
      tick();
      lit("scw3", 4'hC, 2'd2, 1'b1);
      check("scw3_rdy", 32'(oReady), 1);
      tick();

      // scan with stall and live-data change
      iSel = 2'd0; iValid = 1'b1;
      tick();
      iValid = 1'b0;
      iData  = '1;
      lit("sst0", 4'hA, 2'd0, 1'b0);
      tick();
      iReady = 1'b0;
      lit("sst1", 4'hB, 2'd1, 1'b0);
      for (int i = 0; i < 3; i++) begin
         tick();
         lit("stall", 4'hB, 2'd1, 1'b0);
      end
      iReady = 1'b1;
      tick();
      lit("sst2", 4'hC, 2'd2, 1'b0);
      tick();
      lit("sst3", 4'hD, 2'd3, 1'b1);
      tick();
      iData = PAT;

      // reset mid-scan
      iSel = 2'd0; iValid = 1'b1;
      tick();
      iValid = 1'b0;
      tick();
      @(negedge iClk);
      #1 iRst_n = 1'b0;
      #1;
      check("mid_rst_v", 32'(oValid), 0);
      check("mid_rst_d", 32'(oD), 0);
      check("mid_rst_ch", 32'(oCh), 0);
      check("mid_rst_last", 32'(oLast), 0);
      check("mid_rst_rdy", 32'(oReady), 0);
      repeat (2) tick();
      iRst_n = 1'b1;
      tick();
      iMode = 1'b0; iSel = 2'd1; iValid = 1'b1;
      tick();
      iValid = 1'b0;
      lit("post_rst", 4'hB, 2'd1, 1'b1);
      tick();

      // random traffic against the model
      for (int n = 0; n < 600; n++) begin
         iValid = ($urandom_range(0, 2) != 0);
         iMode  = 1'($urandom);
         iSel   = 2'($urandom);
         iData  = 16'($urandom);
         iReady = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 149) == 0) begin
            iRst_n = 1'b0;
            repeat (2) tick();
            iRst_n = 1'b1;
         end
         tick();
      end
      iValid = 1'b0;
      iReady = 1'b1;
      repeat (12) tick();
      @(negedge iClk);
      run = 1'b0;
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
